// File: rtl/cook_timer_fsm_pkg.sv
// Shared encodings for the cook-cycle controller and the PWM heater generator.
package cook_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] LVL_LOW    = 2'b00;
  localparam logic [1:0] LVL_MEDIUM = 2'b01;
  localparam logic [1:0] LVL_NORMAL = 2'b10;
  localparam logic [1:0] LVL_HIGH   = 2'b11;

  localparam logic [6:0] MAX_MINUTES = 7'd99;
  localparam logic [5:0] MAX_SECONDS = 6'd59;

  function automatic logic [6:0] clamp_min(input logic [6:0] m);
    return (m > MAX_MINUTES) ? MAX_MINUTES : m;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > MAX_SECONDS) ? MAX_SECONDS : s;
  endfunction

endpackage

// File: rtl/cook_timer_fsm_if.sv
// Control/status bundle between the front panel and the cook timer.
interface cook_timer_fsm_if;
  logic       load;
  logic [6:0] set_minutes;
  logic [5:0] set_seconds;
  logic [1:0] level_in;
  logic       start;
  logic       stop;
  logic       door_open;
  logic       heat_enable;
  logic [1:0] heating_level;
  logic [6:0] minutes_left;
  logic [5:0] seconds_left;
  logic       done;
  logic [1:0] state_out;

  modport master (
    output load, set_minutes, set_seconds, level_in, start, stop, door_open,
    input  heat_enable, heating_level, minutes_left, seconds_left, done, state_out
  );

  modport slave (
    input  load, set_minutes, set_seconds, level_in, start, stop, door_open,
    output heat_enable, heating_level, minutes_left, seconds_left, done, state_out
  );
endinterface

// File: rtl/cook_timer_fsm_sec_tick_gen.sv
// One-second prescaler: counts 0..CLOCK_FREQUENCY-1, tick on terminal count.
module sec_tick_gen #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);
  localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLOCK_FREQUENCY - 1);

  logic [PW-1:0] r_cnt;

  assign o_tick = !i_clear && !i_hold && (r_cnt == TERM);

  always_ff @(posedge clock) begin
    if (reset || i_clear) r_cnt <= '0;
    else if (!i_hold)     r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/cook_timer_fsm.sv
// Cook-cycle controller: MM:SS countdown driving the PWM heater enable/level.
module cook_timer_fsm
  import cook_pkg::*;
#(
  parameter int CLOCK_FREQUENCY   = 50000000,
  parameter int DONE_BEEP_SECONDS = 3
) (
  input  logic              clock,
  input  logic              reset,
  cook_timer_fsm_if.slave   bus
);
  localparam int DW = (DONE_BEEP_SECONDS > 0) ? $clog2(DONE_BEEP_SECONDS + 1) : 1;
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_BEEP_SECONDS - 1);

  state_e        r_state;
  logic          r_heat;
  logic          r_done;
  logic [1:0]    r_lvl;
  logic [6:0]    r_min;
  logic [5:0]    r_sec;
  logic [DW-1:0] r_dcnt;

  state_e     w_next;
  logic [6:0] w_min;
  logic [5:0] w_sec;
  logic [1:0] w_lvl;
  logic       w_tick, w_clear, w_hold, w_run;

  // The prescaler only advances on edges where we stay in COOKING/DONE, so a
  // pause freezes it at the exact count seen on the cycle stop/door arrived.
  // Entering DONE needs no explicit clear: the terminal tick already wraps it.
  assign w_run   = (r_state == ST_COOKING && !bus.stop && !bus.door_open) ||
                   (r_state == ST_DONE    && !bus.stop);
  assign w_clear = (r_state == ST_IDLE);
  assign w_hold  = !w_run;

  sec_tick_gen #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_clear),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next = r_state;
    w_min  = r_min;
    w_sec  = r_sec;
    w_lvl  = r_lvl;
    case (r_state)
      ST_IDLE: begin
        if (bus.stop) begin
          w_min = '0;
          w_sec = '0;
        end else if (bus.start && !bus.door_open && (r_min != 0 || r_sec != 0)) begin
          w_next = ST_COOKING;
          w_lvl  = bus.level_in;
        end else if (bus.load) begin
          w_min = clamp_min(bus.set_minutes);
          w_sec = clamp_sec(bus.set_seconds);
        end
      end
      ST_COOKING: begin
        if (bus.stop || bus.door_open) begin
          w_next = ST_PAUSED;
        end else if (w_tick) begin
          if (r_sec != 0) begin
            w_sec = r_sec - 6'd1;
          end else if (r_min != 0) begin
            w_min = r_min - 7'd1;
            w_sec = MAX_SECONDS;
          end
          if (r_min == 0 && r_sec <= 6'd1) w_next = ST_DONE;
        end
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          w_next = ST_IDLE;
          w_min  = '0;
          w_sec  = '0;
        end else if (bus.start && !bus.door_open) begin
          w_next = ST_COOKING;
        end
      end
      ST_DONE: begin
        if (bus.stop || (w_tick && r_dcnt == DONE_LAST)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_heat  <= 1'b0;
      r_done  <= 1'b0;
      r_lvl   <= LVL_NORMAL;
      r_min   <= '0;
      r_sec   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_heat  <= (w_next == ST_COOKING);
      r_done  <= (w_next == ST_DONE);
      r_lvl   <= w_lvl;
      r_min   <= w_min;
      r_sec   <= w_sec;
      if (r_state != ST_DONE) r_dcnt <= '0;
      else if (w_tick)        r_dcnt <= r_dcnt + 1'b1;
    end
  end

  assign bus.heat_enable   = r_heat;
  assign bus.heating_level = r_lvl;
  assign bus.minutes_left  = r_min;
  assign bus.seconds_left  = r_sec;
  assign bus.done          = r_done;
  assign bus.state_out     = r_state;
endmodule

// File: tb/tb_cook_timer_fsm.sv
// Directed bench for cook_timer_fsm with a 10-cycle second and 3 s done beep.
module tb_cook_timer_fsm;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cook_timer_fsm_if bus();

  cook_timer_fsm #(.CLOCK_FREQUENCY(10), .DONE_BEEP_SECONDS(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_load(input logic [6:0] m, input logic [5:0] s);
    bus.set_minutes = m; bus.set_seconds = s; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] lvl);
    bus.level_in = lvl; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int m, input int s);
    chk({tag, "_min"}, 32'(bus.minutes_left), 32'(m));
    chk({tag, "_sec"}, 32'(bus.seconds_left), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.state_out), 0);
    chk({tag, "_heat"},  32'(bus.heat_enable), 0);
    chk({tag, "_lvl"},   32'(bus.heating_level), 2);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk_time(tag, 0, 0);
  endtask

  initial begin
    bus.load = 0; bus.set_minutes = 0; bus.set_seconds = 0; bus.level_in = 0;
    bus.start = 0; bus.stop = 0; bus.door_open = 0;
    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Full cycle 0:03 at high level, then done beep
    pulse_load(7'd0, 6'd3);
    chk_time("load3", 0, 3);
    pulse_start(2'b11);
    chk("run_heat", 32'(bus.heat_enable), 1);
    chk("run_lvl", 32'(bus.heating_level), 3);
    chk("run_state", 32'(bus.state_out), 1);
    step(9);  chk_time("pre_tick", 0, 3);
    step(1);  chk_time("tick1", 0, 2);
    step(10); chk_time("tick2", 0, 1);
    step(10); chk_time("tick3", 0, 0);
    chk("done_state", 32'(bus.state_out), 3);
    chk("done_hi", 32'(bus.done), 1);
    chk("done_heat", 32'(bus.heat_enable), 0);
    step(29); chk("done_29", 32'(bus.done), 1);
    step(1);
    chk("done_end", 32'(bus.done), 0);
    chk("done_idle", 32'(bus.state_out), 0);

    // Minute borrow, then stop+start together pauses, second stop clears
    pulse_load(7'd1, 6'd0);
    pulse_start(2'b01);
    step(10); chk_time("borrow", 0, 59);
    chk("borrow_state", 32'(bus.state_out), 1);
    bus.stop = 1; bus.start = 1;
    step(1);
    bus.stop = 0; bus.start = 0;
    chk("ss_state", 32'(bus.state_out), 2);
    chk("ss_heat", 32'(bus.heat_enable), 0);
    chk_time("ss_time", 0, 59);
    pulse_stop();
    chk("stop2_state", 32'(bus.state_out), 0);
    chk_time("stop2", 0, 0);

    // Door opens mid-second: prescaler held, resumes 6 cycles from tick
    pulse_load(7'd0, 6'd5);
    pulse_start(2'b01);
    step(14); chk_time("door_pre", 0, 4);
    bus.door_open = 1;
    step(1);
    chk("door_state", 32'(bus.state_out), 2);
    chk("door_heat", 32'(bus.heat_enable), 0);
    step(20); chk_time("door_frozen", 0, 4);
    pulse_start(2'b01);
    chk("door_start", 32'(bus.state_out), 2);
    bus.door_open = 0;
    pulse_start(2'b01);
    chk("resume_state", 32'(bus.state_out), 1);
    chk("resume_heat", 32'(bus.heat_enable), 1);
    step(5); chk_time("resume5", 0, 4);
    step(1); chk_time("resume6", 0, 3);
    pulse_stop(); pulse_stop();
    chk("door_clr", 32'(bus.state_out), 0);

    // Door opening on the tick cycle discards the tick
    pulse_load(7'd0, 6'd2);
    pulse_start(2'b00);
    step(9);
    bus.door_open = 1;
    step(1);
    chk("dtick_state", 32'(bus.state_out), 2);
    chk_time("dtick", 0, 2);
    bus.door_open = 0;
    pulse_stop();

    // Ignored starts in IDLE: zero time, door open
    pulse_start(2'b11);
    chk("zero_state", 32'(bus.state_out), 0);
    chk("zero_heat", 32'(bus.heat_enable), 0);
    pulse_load(7'd0, 6'd2);
    bus.door_open = 1;
    pulse_start(2'b11);
    chk("open_state", 32'(bus.state_out), 0);
    chk("open_heat", 32'(bus.heat_enable), 0);
    bus.door_open = 0;

    // Load clamping and upper boundary
    pulse_load(7'd3, 6'd63);
    chk_time("clamp_sec", 3, 59);
    pulse_load(7'd99, 6'd59);
    chk_time("max_load", 99, 59);
    pulse_stop();
    chk_time("idle_stop", 0, 0);

    // Stop during DONE returns to IDLE immediately
    pulse_load(7'd0, 6'd1);
    pulse_start(2'b00);
    step(10);
    chk("dn_state", 32'(bus.state_out), 3);
    pulse_stop();
    chk("dn_stop_state", 32'(bus.state_out), 0);
    chk("dn_stop_done", 32'(bus.done), 0);

    // Reset mid-cook
    pulse_load(7'd0, 6'd9);
    pulse_start(2'b11);
    step(5);
    reset = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    reset = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
